keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad and turns one debounced key press into a single-cycle keystrobe with a 4-bit keycode. It sits directly upstream of the calculator's key decoder. That decoder consumes keystrobe/keycode using this encoding: 0-9 digits, 10 clear, 11 execute, 12 divide, 13 multiply, 14 subtract, 15 add. The block owns row drive, column synchronisation, debounce, multi-key rejection and press/release tracking.

Parameters:
SCAN_DIV, 1000, clock cycles each row is driven; must be >= 4.
DEBOUNCE_SCANS, 4, consecutive full frames a condition must hold before press or release is accepted; must be >= 1.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
col_n  input  4  keypad columns, active-low (external pull-ups), asynchronous
row_n  output  4  keypad row drive, active-low, exactly one row low at a time
keystrobe  output  1  one-cycle pulse per accepted key press
keycode  output  4  code of the last accepted key; valid with keystrobe, held afterwards
key_held  output  1  high from the accepted press until the accepted release

Behaviour:
- Reset values: row_n=4'b1110, keystrobe=0, keycode=0, key_held=0, FSM=IDLE, all counters and synchroniser flops cleared (synchronisers to 4'b1111). Reset mid-scan or mid-debounce abandons all state; no strobe is produced.
- Synchroniser: col_n passes through 2 flops before use.
- Scan: row r (0..3) is driven low for SCAN_DIV cycles, in order 0,1,2,3,0,... A frame is 4*SCAN_DIV cycles.
- Sampling: the synchronised columns are sampled on the last cycle of each row period. Column c low means key (r,c) is pressed.
- Key index: idx = 4*r + c. Per frame, the block accumulates the count of pressed keys (saturating at 2) and the index of the last pressed key.
- Keymap (row r: col0..col3):
  - row0: 1, 2, 3, 15
  - row1: 4, 5, 6, 14
  - row2: 7, 8, 9, 13
  - row3: 10, 0, 11, 12
- Frame evaluation happens on the frame-end cycle (last cycle of row 3). It classifies the frame as NONE, ONE(idx) or MULTI. The accumulators clear for the next frame.
- FSM transitions, taken at frame end only:
  - IDLE:
    - ONE(i): cand=i, cnt=1. If DEBOUNCE_SCANS==1, accept immediately; otherwise go to DEBOUNCE.
    - NONE or MULTI: stay in IDLE.
  - DEBOUNCE:
    - ONE(cand): cnt++. On cnt==DEBOUNCE_SCANS, accept.
    - NONE, MULTI or ONE(other): return to IDLE. No strobe.
  - Accept: keystrobe=1 for exactly the cycle after frame end, keycode=map(cand) in that same cycle, key_held=1, go to HELD.
  - HELD:
    - NONE: rcnt++. On rcnt==DEBOUNCE_SCANS, key_held=0 (cycle after frame end) and go to IDLE.
    - ONE or MULTI (any key): rcnt=0. No repeat strobes, no keycode change.
- keycode changes only on accept and otherwise holds its value indefinitely.
- Row scanning never stalls. It is independent of FSM state.
- Frame-end latency: keystrobe rises one cycle after the frame end of the DEBOUNCE_SCANS-th consecutive ONE frame.

Test Plan:
1. SCAN_DIV=4, DEBOUNCE_SCANS=3, press (row1,col2) from cycle 0 and hold -> exactly one keystrobe, in cycle 48 after reset release (frame ends at cycles 15, 31, 47). keycode=6 in that cycle. key_held=1. No further strobes while held.
2. Same press, then release -> key_held falls one cycle after the 3rd consecutive empty frame end. keycode stays 6. A subsequent press of (row3,col0) -> strobe with keycode=10.
3. Bounce: (row0,col3) pressed for 2 frames, open 1 frame, then held -> no strobe until 3 consecutive ONE frames after the gap, then one strobe with keycode=15.
4. Multi-key: (row2,col3) and (row3,col3) pressed together -> no strobe ever. Releasing (row3,col3) while still holding (row2,col3) -> strobe keycode=13 after 3 frames.
5. Reset mid-operation: hold (row3,col1), assert reset during the 2nd frame -> row_n=4'b1110, keystrobe=0, key_held=0 next cycle. After release of reset, a strobe with keycode=0 occurs 3 full frames later.
6. Row drive check -> row_n cycles 1110, 1101, 1011, 0111, with each value held exactly SCAN_DIV cycles and exactly one bit low at all times.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: matrix drive/sense towards the keypad and the
// keystrobe/keycode/key_held stream towards the calculator key decoder.
interface keypad_scanner_if;
  logic [3:0] col_n;      // keypad columns, active-low, asynchronous
  logic [3:0] row_n;      // row drive, active-low, one row low at a time
  logic       keystrobe;  // one-cycle pulse per accepted press
  logic [3:0] keycode;    // code of the last accepted key
  logic       key_held;   // high from accepted press to accepted release

  // Scanner side.
  modport master (
    input  col_n,
    output row_n,
    output keystrobe,
    output keycode,
    output key_held
  );

  // Keypad / decoder side.
  modport slave (
    output col_n,
    input  row_n,
    input  keystrobe,
    input  keycode,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner. Drives one row low at a time, samples the
// synchronised columns at the end of each row period, classifies every full
// frame as NONE / ONE(idx) / MULTI and debounces press and release over
// DEBOUNCE_SCANS frames. An accepted press gives a single keystrobe with the
// calculator keycode; key_held tracks the press until its debounced release.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 1000,  // cycles per row, >= 4
  parameter int unsigned DEBOUNCE_SCANS = 4      // frames to accept, >= 1
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.master io_kp
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] DebN    = CntW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    StIdle,
    StDebounce,
    StHeld
  } state_t;

  // Matrix position (4*row + col) to calculator keycode.
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = 4'd15;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = 4'd14;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = 4'd13;
      4'd12:   code = 4'd10;
      4'd13:   code = 4'd0;
      4'd14:   code = 4'd11;
      default: code = 4'd12;
    endcase
    return code;
  endfunction

  // Column synchroniser.
  logic [3:0]      r_col_s1;
  logic [3:0]      r_col_s2;

  // Row scanner.
  logic [DivW-1:0] r_div;
  logic [1:0]      r_row;
  logic [3:0]      r_row_n;

  // Per-frame accumulators.
  logic [1:0]      r_acc_cnt;
  logic [3:0]      r_acc_idx;

  // Debounce FSM and registered outputs.
  state_t          r_state;
  logic [3:0]      r_cand;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] r_rcnt;
  logic            r_keystrobe;
  logic [3:0]      r_keycode;
  logic            r_key_held;

  logic            w_row_last;
  logic            w_frame_end;
  logic [3:0]      w_pressed;
  logic [1:0]      w_row_cnt;
  logic [1:0]      w_row_col;
  logic [2:0]      w_sum;
  logic [1:0]      w_frame_cnt;
  logic [3:0]      w_frame_idx;
  logic            w_one;
  logic            w_none;

  assign w_row_last  = (r_div == DivLast);
  assign w_frame_end = w_row_last && (r_row == 2'd3);
  assign w_pressed   = ~r_col_s2;

  // Pressed-key count (saturating at 2) and highest pressed column of the current row.
  always_comb begin
    w_row_cnt = 2'd0;
    w_row_col = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (w_pressed[c]) begin
        w_row_col = 2'(c);
        if (w_row_cnt != 2'd2) begin
          w_row_cnt = w_row_cnt + 2'd1;
        end
      end
    end
  end

  // Running frame totals including the row being sampled this cycle.
  always_comb begin
    w_sum       = {1'b0, r_acc_cnt} + {1'b0, w_row_cnt};
    w_frame_cnt = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    // Later rows/columns win, so this is the last pressed key in scan order.
    w_frame_idx = (w_row_cnt != 2'd0) ? {r_row, w_row_col} : r_acc_idx;
    w_one       = (w_frame_cnt == 2'd1);
    w_none      = (w_frame_cnt == 2'd0);
  end

  // Two-flop synchroniser for the asynchronous column inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col_s1 <= 4'b1111;
      r_col_s2 <= 4'b1111;
    end else begin
      r_col_s1 <= io_kp.col_n;
      r_col_s2 <= r_col_s1;
    end
  end

  // Free-running row scan: each row low for SCAN_DIV cycles, order 0,1,2,3.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div   <= '0;
      r_row   <= 2'd0;
      r_row_n <= 4'b1110;
    end else if (w_row_last) begin
      r_div   <= '0;
      r_row   <= r_row + 2'd1;
      r_row_n <= {r_row_n[2:0], r_row_n[3]};
    end else begin
      r_div   <= r_div + DivW'(1);
    end
  end

  // Accumulate row samples over a frame; cleared once the frame is evaluated.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_cnt <= 2'd0;
      r_acc_idx <= 4'd0;
    end else if (w_frame_end) begin
      r_acc_cnt <= 2'd0;
      r_acc_idx <= 4'd0;
    end else if (w_row_last) begin
      r_acc_cnt <= w_frame_cnt;
      r_acc_idx <= w_frame_idx;
    end
  end

  // Press/release debounce FSM; advances only on frame-end cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cand      <= 4'd0;
      r_cnt       <= '0;
      r_rcnt      <= '0;
      r_keystrobe <= 1'b0;
      r_keycode   <= 4'd0;
      r_key_held  <= 1'b0;
    end else begin
      r_keystrobe <= 1'b0;
      if (w_frame_end) begin
        case (r_state)
          StIdle: begin
            if (w_one) begin
              r_cand <= w_frame_idx;
              r_cnt  <= CntW'(1);
              if (DEBOUNCE_SCANS == 1) begin
                r_keystrobe <= 1'b1;
                r_keycode   <= key_map(w_frame_idx);
                r_key_held  <= 1'b1;
                r_rcnt      <= '0;
                r_state     <= StHeld;
              end else begin
                r_state <= StDebounce;
              end
            end
          end
          StDebounce: begin
            if (w_one && (w_frame_idx == r_cand)) begin
              r_cnt <= r_cnt + CntW'(1);
              if ((r_cnt + CntW'(1)) == DebN) begin
                r_keystrobe <= 1'b1;
                r_keycode   <= key_map(r_cand);
                r_key_held  <= 1'b1;
                r_rcnt      <= '0;
                r_state     <= StHeld;
              end
            end else begin
              // Empty, multi-key or a different key restarts the press search.
              r_state <= StIdle;
            end
          end
          StHeld: begin
            if (w_none) begin
              if ((r_rcnt + CntW'(1)) == DebN) begin
                r_rcnt     <= '0;
                r_key_held <= 1'b0;
                r_state    <= StIdle;
              end else begin
                r_rcnt <= r_rcnt + CntW'(1);
              end
            end else begin
              // Any key activity while held restarts release debounce.
              r_rcnt <= '0;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign io_kp.row_n     = r_row_n;
  assign io_kp.keystrobe = r_keystrobe;
  assign io_kp.keycode   = r_keycode;
  assign io_kp.key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// A behavioural keypad pulls a column low when its key is pressed and its row
// is driven. Cycle 0 is the first cycle after reset is released.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV       = 4;
  localparam int unsigned DEBOUNCE_SCANS = 3;

  logic        clk;
  logic        reset;
  logic [15:0] pressed;
  logic [3:0]  kp_col;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_kp (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: key (r,c) shorts row r to column c.
  always_comb begin
    kp_col = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!kp.row_n[r] && pressed[4*r+c]) kp_col[c] = 1'b0;
      end
    end
  end
  assign kp.col_n = kp_col;

  int         n_assert;
  int         n_fail;
  int         cyc;
  int         n_strobe;
  int         strobe_cyc;
  int         strobe_code;
  int         fall_cyc;
  logic       prev_held;
  logic [3:0] exp_row;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    n_strobe    = 0;
    strobe_cyc  = -1;
    strobe_code = -1;
    fall_cyc    = -1;
  endtask

  // One clock: check row drive, record strobes and key_held falling edges.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    exp_row = 4'b1111;
    exp_row[(cyc / SCAN_DIV) % 4] = 1'b0;
    check("row_n", 32'(kp.row_n), 32'(exp_row));
    check("one_row_low", $countones(~kp.row_n), 1);
    if (kp.keystrobe === 1'b1) begin
      n_strobe++;
      strobe_cyc  = cyc;
      strobe_code = int'(kp.keycode);
    end
    if (prev_held && (kp.key_held === 1'b0)) fall_cyc = cyc;
    prev_held = kp.key_held;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    cyc       = 0;
    prev_held = 1'b0;
    pressed   = '0;
    reset     = 1'b1;
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    check("reset_row_n", 32'(kp.row_n), 32'h0000_000e);
    check("reset_keystrobe", 32'(kp.keystrobe), 0);
    check("reset_keycode", 32'(kp.keycode), 0);
    check("reset_key_held", 32'(kp.key_held), 0);

    // Press (row1,col2) from cycle 0: frames end 15,31,47 -> strobe in 48.
    pressed = 16'h0040;
    reset   = 1'b0;
    run_to(63);
    check("t1_strobes", n_strobe, 1);
    check("t1_strobe_cycle", strobe_cyc, 48);
    check("t1_keycode", strobe_code, 6);
    check("t1_key_held", 32'(kp.key_held), 1);

    // Release: empty frames end 79,95,111 -> key_held falls in 112.
    pressed = '0;
    clear_obs();
    run_to(127);
    check("t2_release_cycle", fall_cyc, 112);
    check("t2_keycode_hold", 32'(kp.keycode), 6);
    check("t2_no_strobe", n_strobe, 0);
    // Press (row3,col0): frames end 143,159,175 -> strobe in 176, code 10.
    pressed = 16'h1000;
    clear_obs();
    run_to(191);
    check("t2_strobes", n_strobe, 1);
    check("t2_strobe_cycle", strobe_cyc, 176);
    check("t2_keycode", strobe_code, 10);
    pressed = '0;
    clear_obs();
    run_to(255);
    check("t2_release2_cycle", fall_cyc, 240);

    // Bounce on (row0,col3): ONE,ONE,NONE then ONE x3 ending 351 -> strobe 352.
    pressed = 16'h0008;
    clear_obs();
    run_to(287);
    pressed = '0;
    run_to(303);
    pressed = 16'h0008;
    run_to(367);
    check("t3_strobes", n_strobe, 1);
    check("t3_strobe_cycle", strobe_cyc, 352);
    check("t3_keycode", strobe_code, 15);
    pressed = '0;
    clear_obs();
    run_to(431);
    check("t3_release_cycle", fall_cyc, 416);

    // Multi-key (row2,col3)+(row3,col3): never accepted.
    pressed = 16'h8800;
    clear_obs();
    run_to(495);
    check("t4_multi_no_strobe", n_strobe, 0);
    check("t4_multi_not_held", 32'(kp.key_held), 0);
    // Drop (row3,col3): ONE(11) frames end 511,527,543 -> strobe 544, code 13.
    pressed = 16'h0800;
    run_to(559);
    check("t4_strobes", n_strobe, 1);
    check("t4_strobe_cycle", strobe_cyc, 544);
    check("t4_keycode", strobe_code, 13);
    pressed = '0;
    clear_obs();
    run_to(623);
    check("t4_release_cycle", fall_cyc, 608);

    // Hold (row3,col1), reset during the second frame.
    pressed = 16'h2000;
    clear_obs();
    run_to(645);
    check("t5_pre_reset_no_strobe", n_strobe, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t5_reset_row_n", 32'(kp.row_n), 32'h0000_000e);
    check("t5_reset_keystrobe", 32'(kp.keystrobe), 0);
    check("t5_reset_key_held", 32'(kp.key_held), 0);
    check("t5_reset_keycode", 32'(kp.keycode), 0);
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    cyc       = 0;
    prev_held = 1'b0;
    clear_obs();
    run_to(63);
    check("t5_strobes", n_strobe, 1);
    check("t5_strobe_cycle", strobe_cyc, 48);
    check("t5_keycode", strobe_code, 0);
    check("t5_key_held", 32'(kp.key_held), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
